// File: rtl/shake128_squeezer_pkg.sv
// Shared types and constants for the SHAKE128 squeezer.
package shake128_squeezer_pkg;
    localparam int LANE_W              = 64;
    localparam int STATE_W             = 1600;
    localparam int NUM_LANES           = 25;
    localparam int SHAKE128_RATE_LANES = 21;
    localparam int IDX_W               = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EMIT = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } sqz_state_e;
endpackage

// File: rtl/shake128_squeezer_lane_mux.sv
// Picks one 64-bit lane out of the 1600-bit Keccak state by lane index.
module shake_lane_mux
    import shake128_squeezer_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [LANE_W-1:0]  lane_o
);
    logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
    assign lanes = state_i;

    // One-hot compare against every lane; indices past lane 24 yield zero.
    always_comb begin
        lane_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (idx_i == IDX_W'(i)) lane_o = lanes[i];
        end
    end
endmodule

// File: rtl/shake128_squeezer.sv
// SHAKE128 output squeezer: streams rate lanes of the Keccak state and asks
// the permutation core for a fresh state after every full rate block.
// Optional feature: define SHAKE_SQZ_PERF_EN to add the saturating
// perm_count output (number of perm_req pulses since reset).
module shake128_squeezer
    import shake128_squeezer_pkg::*;
#(
    parameter int RATE_LANES = SHAKE128_RATE_LANES,
    parameter int LEN_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len_words,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               perm_req,
    output logic [STATE_W-1:0] perm_state_out,
    output logic [LANE_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
`ifdef SHAKE_SQZ_PERF_EN
    ,
    output logic [15:0]        perm_count
`endif
);
    sqz_state_e         state_q;
    logic [STATE_W-1:0] buf_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LEN_W-1:0]   rem_q;
    logic               out_valid_q;
    logic               perm_req_q;
    logic               busy_q;
    logic               done_q;

    assign perm_state_out = buf_q;
    assign out_valid      = out_valid_q;
    assign perm_req       = perm_req_q;
    assign busy           = busy_q;
    assign done           = done_q;

    shake_lane_mux u_lane_mux (
        .state_i (buf_q),
        .idx_i   (idx_q),
        .lane_o  (out_data)
    );

    // Squeeze FSM; outputs are registered alongside each state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            perm_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_words == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else if (state_valid) begin
                            buf_q       <= state_in;
                            rem_q       <= len_words;
                            idx_q       <= '0;
                            state_q     <= EMIT;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // rem_q is at least 1 here, so the decrement cannot wrap.
                    if (out_ready) begin
                        rem_q <= rem_q - LEN_W'(1);
                        idx_q <= idx_q + IDX_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else if (idx_q == IDX_W'(RATE_LANES - 1)) begin
                            state_q     <= REQ;
                            idx_q       <= '0;
                            perm_req_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                // state_valid is deliberately not looked at while requesting.
                REQ: state_q <= WAIT;
                WAIT: begin
                    if (state_valid) begin
                        buf_q       <= state_in;
                        state_q     <= EMIT;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHAKE_SQZ_PERF_EN
    logic [15:0] perm_count_q;
    assign perm_count = perm_count_q;

    // Saturating count of permutation requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_count_q <= '0;
        end else if (perm_req_q && perm_count_q != 16'hFFFF) begin
            perm_count_q <= perm_count_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shake128_squeezer.sv
// Directed bench for shake128_squeezer with a word scoreboard.
module tb_shake128_squeezer;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   len_words = '0;
    logic [1599:0] state_in = '0;
    logic          state_valid = 1'b0;
    logic          perm_req;
    logic [1599:0] perm_state_out;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
`ifdef SHAKE_SQZ_PERF_EN
    logic [15:0]   perm_count;
`endif

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    logic [63:0] sb[$];
    logic [63:0] cur_base = '0;
    bit   rdy_mode = 1'b0;
    int   ph = 0;
    bit   hold_pending = 1'b0;
    logic [63:0] held_data = '0;

    shake128_squeezer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .len_words      (len_words),
        .state_in       (state_in),
        .state_valid    (state_valid),
        .perm_req       (perm_req),
        .perm_state_out (perm_state_out),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done)
`ifdef SHAKE_SQZ_PERF_EN
        ,
        .perm_count     (perm_count)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1599:0] mk(input logic [63:0] b);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) s[i*64 +: 64] = b + 64'(i);
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ready pattern 1,0,0 repeating when enabled, otherwise always ready.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode) begin
            out_ready = (ph == 0);
            ph = (ph + 1) % 3;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor: stall hold check and scoreboard pop on each transfer.
    initial forever begin
        @(negedge clk);
        if (out_valid && hold_pending) check("hold", out_data, held_data);
        hold_pending = out_valid && !out_ready;
        held_data    = out_data;
        if (out_valid && out_ready) begin
            xfers++;
            if (sb.size() == 0) begin
                check("extra_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("word", out_data, e);
            end
        end
    end

    task automatic do_start(input int len, input logic [63:0] base);
        @(posedge clk);
        #1;
        start = 1'b1;
        len_words = 16'(len);
        state_in = mk(base);
        state_valid = 1'b1;
        cur_base = base;
        for (int k = 0; k < len; k++)
            sb.push_back(base + 64'(k / 21) * 64'h100000 + 64'(k % 21));
        @(posedge clk);
        #1;
        start = 1'b0;
        state_valid = 1'b0;
    endtask

    // Runs until done; answers each perm_req after a stall, and drives a
    // bogus state_valid during the request cycle which must be ignored.
    task automatic run(input int max_cyc, output int perms, output int cyc);
        int  wait_cnt;
        bit  got_done;
        wait_cnt = -1;
        perms = 0;
        got_done = 1'b0;
        for (cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (perm_req) begin
                perms++;
                state_in = mk(64'hBAD0000);
                state_valid = 1'b1;
                wait_cnt = 3;
            end else if (wait_cnt > 0) begin
                state_valid = 1'b0;
                wait_cnt--;
                check("stall_valid", {63'b0, out_valid}, 64'd0);
            end else if (wait_cnt == 0) begin
                state_in = mk(cur_base + 64'(perms) * 64'h100000);
                state_valid = 1'b1;
                wait_cnt = -1;
            end else begin
                state_valid = 1'b0;
            end
        end
        state_valid = 1'b0;
        check("done_seen", {63'b0, got_done}, 64'd1);
    endtask

    initial begin
        int perms, cyc, x0;
        bit got_req;

        // Reset state
        @(negedge clk);
        check("rst_outs", {60'b0, out_valid, busy, done, perm_req}, 64'd0);
        check("rst_buf", {63'b0, perm_state_out === '0}, 64'd1);
`ifdef SHAKE_SQZ_PERF_EN
        check("rst_pcnt", {48'b0, perm_count}, 64'd0);
`endif
        rst = 1'b0;

        // Test 1: three words back to back
        x0 = xfers;
        do_start(3, 64'h1000);
        run(50, perms, cyc);
        check("t1_cycles", 64'(cyc), 64'd3);
        check("t1_perms", 64'(perms), 64'd0);
        check("t1_xfers", 64'(xfers - x0), 64'd3);
        check("t1_sb", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("t1_done_pulse", {62'b0, done, busy}, 64'd0);

        // Test 2: cross a rate block
        x0 = xfers;
        do_start(23, 64'h2000);
        run(200, perms, cyc);
        check("t2_perms", 64'(perms), 64'd1);
        check("t2_xfers", 64'(xfers - x0), 64'd23);
        check("t2_sb", 64'(sb.size()), 64'd0);

        // Test 3: backpressure
        rdy_mode = 1'b1;
        @(posedge clk);
        x0 = xfers;
        do_start(4, 64'h3000);
        run(100, perms, cyc);
        check("t3_xfers", 64'(xfers - x0), 64'd4);
        check("t3_sb", 64'(sb.size()), 64'd0);
        rdy_mode = 1'b0;
        @(posedge clk);

        // Test 4: zero-length request
        x0 = xfers;
        do_start(0, 64'h4000);
        @(negedge clk);
        check("t4_done", {62'b0, done, out_valid}, 64'd2);
        check("t4_buf_kept", {63'b0, perm_state_out === mk(64'h3000)}, 64'd1);
        @(negedge clk);
        check("t4_after", {61'b0, done, busy, out_valid}, 64'd0);
        check("t4_xfers", 64'(xfers - x0), 64'd0);

        // Test 5: reset while waiting for the permutation
        do_start(50, 64'h5000);
        got_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (perm_req) begin
                got_req = 1'b1;
                break;
            end
        end
        check("t5_req_seen", {63'b0, got_req}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_outs", {60'b0, out_valid, busy, done, perm_req}, 64'd0);
        check("t5_rst_buf", {63'b0, perm_state_out === '0}, 64'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
`ifdef SHAKE_SQZ_PERF_EN
        check("t5_pcnt", {48'b0, perm_count}, 64'd0);
`endif
        x0 = xfers;
        do_start(2, 64'h6000);
        run(50, perms, cyc);
        check("t5_xfers", 64'(xfers - x0), 64'd2);
        check("t5_sb", 64'(sb.size()), 64'd0);

`ifdef SHAKE_SQZ_PERF_EN
        // Test 6: permutation counter
        do_start(64, 64'h7000);
        run(600, perms, cyc);
        check("t6_pcnt", {48'b0, perm_count}, 64'd3);
        check("t6_sb", 64'(sb.size()), 64'd0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
